mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl.sv | 122 ++++++++++++
 tb/tb_mem_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Memory controller: sequences single-word reads (WAIT_CYCLES strobe hold) and
// three-phase writes to a 512-word RAM, rejecting out-of-range bus addresses.
module mem_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start_read,
  input  logic        start_write,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  input  logic [31:0] ram_rdata,
  output logic        ram_read,
  output logic        ram_write,
  output logic [8:0]  ram_addr,
  output logic [31:0] ram_wdata,
  output logic [31:0] rdata_out,
  output logic        busy,
  output logic        done,
  output logic        addr_err
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    DONE
  } state_t;

  localparam logic [3:0] RD_LAST = 4'(WAIT_CYCLES - 1);

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [8:0]  addr_n;
  logic [31:0] wdata_n, rdata_n;
  logic        read_n, write_n, done_n, err_n;
  logic        addr_ok;

  assign addr_ok = (addr_in[31:9] == '0);
  assign busy    = (state != IDLE);

  // Strobes and pulses are computed one state ahead so every output leaves a flop.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    addr_n  = ram_addr;
    wdata_n = ram_wdata;
    rdata_n = rdata_out;
    read_n  = 1'b0;
    write_n = 1'b0;
    done_n  = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_read || start_write) begin
          if (!addr_ok) begin
            err_n = 1'b1;
          end else if (start_read) begin
            addr_n  = addr_in[8:0];
            cnt_n   = '0;
            read_n  = 1'b1;
            state_n = RD;
          end else begin
            addr_n  = addr_in[8:0];
            wdata_n = wdata_in;
            state_n = WR_SETUP;
          end
        end
      end
      RD: begin
        if (cnt == RD_LAST) begin
          rdata_n = ram_rdata;
          done_n  = 1'b1;
          state_n = DONE;
        end else begin
          cnt_n  = cnt + 4'd1;
          read_n = 1'b1;
        end
      end
      WR_SETUP: begin
        write_n = 1'b1;
        state_n = WR_PULSE;
      end
      WR_PULSE: state_n = WR_HOLD;
      WR_HOLD: begin
        done_n  = 1'b1;
        state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= IDLE;
      cnt       <= '0;
      ram_read  <= 1'b0;
      ram_write <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      rdata_out <= '0;
      done      <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      ram_read  <= read_n;
      ram_write <= write_n;
      ram_addr  <= addr_n;
      ram_wdata <= wdata_n;
      rdata_out <= rdata_n;
      done      <= done_n;
      addr_err  <= err_n;
    end
  end

  a_no_overlap : assert property (@(posedge clk) !(ram_read && ram_write));

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a table of single transactions plus hand-written
// sequences for busy-time requests, back-to-back acceptance and mid-flight reset.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        clr, start_read, start_write;
  logic [31:0] addr_in, wdata_in, ram_rdata;
  logic        ram_read, ram_write, busy, done, addr_err;
  logic [8:0]  ram_addr;
  logic [31:0] ram_wdata, rdata_out;

  int checks = 0;
  int errors = 0;

  // per-transaction observations, accumulated at negedge
  int cyc, rd_n, wr_n, wr_cyc, done_n, done_first, done_last, err_n, err_cyc, busy_n, overlap, addr_moves;
  logic [8:0] hold_addr;

  always #5 clk = ~clk;

  mem_ctrl #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .clr(clr), .start_read(start_read), .start_write(start_write),
    .addr_in(addr_in), .wdata_in(wdata_in), .ram_rdata(ram_rdata),
    .ram_read(ram_read), .ram_write(ram_write), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .rdata_out(rdata_out), .busy(busy), .done(done),
    .addr_err(addr_err)
  );

  typedef struct {
    logic        rd, wr;
    logic [31:0] addr, wdata, rdata;
    int          e_rd, e_wrcyc, e_done, e_err, e_busy;
    logic [31:0] e_addr, e_wdata, e_rdata;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic clear_obs();
    cyc = 0; rd_n = 0; wr_n = 0; wr_cyc = 0; done_n = 0; done_first = 0; done_last = 0;
    err_n = 0; err_cyc = 0; busy_n = 0; overlap = 0; addr_moves = 0;
  endtask

  // sample the current cycle at negedge, then advance past the next rising edge
  task automatic step();
    @(negedge clk);
    cyc++;
    if (ram_read) rd_n++;
    if (ram_write) begin wr_n++; wr_cyc = cyc; end
    if (done) begin done_n++; if (done_first == 0) done_first = cyc; done_last = cyc; end
    if (addr_err) begin err_n++; err_cyc = cyc; end
    if (busy) begin busy_n++; if (ram_addr !== hold_addr) addr_moves++; end
    if (ram_read && ram_write) overlap++;
    @(posedge clk); #1;
  endtask

  // drive a request into IDLE, pass the accepting edge, drop the request
  task automatic accept(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] rd);
    start_read = r; start_write = w; addr_in = a; wdata_in = d; ram_rdata = rd;
    hold_addr = a[8:0];
    @(posedge clk); #1;
    start_read = 1'b0; start_write = 1'b0;
    clear_obs();
  endtask

  initial begin
    //        rd   wr   addr          wdata         rdata         rd wc dn er bz  e_addr  e_wdata       e_rdata
    vecs[0] = '{1'b1, 1'b0, 32'h0000_00A5, 32'h0000_0000, 32'hDEAD_BEEF, 2, 0, 3, 0, 3, 32'h0A5, 32'h0000_0000, 32'hDEAD_BEEF};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_01FF, 32'h1234_5678, 32'h0BAD_BAD0, 0, 2, 4, 0, 4, 32'h1FF, 32'h1234_5678, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0000_0000, 32'h5555_5555, 0, 0, 0, 1, 0, 32'h1FF, 32'h1234_5678, 32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_0010, 32'hFFFF_0000, 32'hCAFE_F00D, 2, 0, 3, 0, 3, 32'h010, 32'h1234_5678, 32'hCAFE_F00D};
    vecs[4] = '{1'b0, 1'b1, 32'h8000_0001, 32'h9999_9999, 32'h0000_0000, 0, 0, 0, 1, 0, 32'h010, 32'h1234_5678, 32'hCAFE_F00D};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0001, 2, 0, 3, 0, 3, 32'h000, 32'h1234_5678, 32'h0000_0001};
    vecs[6] = '{1'b0, 1'b1, 32'h0000_00AA, 32'hA5A5_A5A5, 32'h0000_0000, 0, 2, 4, 0, 4, 32'h0AA, 32'hA5A5_A5A5, 32'h0000_0001};

    clr = 1'b1; start_read = 1'b0; start_write = 1'b0;
    addr_in = '0; wdata_in = '0; ram_rdata = '0; hold_addr = '0;
    clear_obs();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_state", {ram_read, ram_write, busy, done, addr_err}, 32'h0);
    check("rst_addr", {23'd0, ram_addr}, 32'h0);
    check("rst_wdata", ram_wdata, 32'h0);
    check("rst_rdata", rdata_out, 32'h0);
    @(posedge clk); #1;
    clr = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      accept(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdata);
      hold_addr = vecs[i].e_addr[8:0];
      for (int c = 0; c < 8; c++) step();
      check($sformatf("v%0d_rd_cycles", i), rd_n, vecs[i].e_rd);
      check($sformatf("v%0d_wr_count", i), wr_n, (vecs[i].e_wrcyc != 0) ? 1 : 0);
      check($sformatf("v%0d_wr_cycle", i), wr_cyc, vecs[i].e_wrcyc);
      check($sformatf("v%0d_done_count", i), done_n, (vecs[i].e_done != 0) ? 1 : 0);
      check($sformatf("v%0d_done_cycle", i), done_first, vecs[i].e_done);
      check($sformatf("v%0d_err_count", i), err_n, (vecs[i].e_err != 0) ? 1 : 0);
      check($sformatf("v%0d_err_cycle", i), err_cyc, vecs[i].e_err);
      check($sformatf("v%0d_busy_cycles", i), busy_n, vecs[i].e_busy);
      check($sformatf("v%0d_strobe_overlap", i), overlap, 0);
      check($sformatf("v%0d_addr_moves", i), addr_moves, 0);
      check($sformatf("v%0d_ram_addr", i), {23'd0, ram_addr}, vecs[i].e_addr);
      check($sformatf("v%0d_ram_wdata", i), ram_wdata, vecs[i].e_wdata);
      check($sformatf("v%0d_rdata_out", i), rdata_out, vecs[i].e_rdata);
    end

    // start_write held through the whole write and into the following IDLE cycle
    start_read = 1'b0; start_write = 1'b1; addr_in = 32'h055; wdata_in = 32'h1111_1111;
    hold_addr = 9'h055;
    @(posedge clk); #1;
    clear_obs();
    addr_in = 32'h066;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 3) check("rep_addr_held", {23'd0, ram_addr}, 32'h055);
      if (c == 4) hold_addr = 9'h066;
      if (c == 5) start_write = 1'b0;
    end
    check("rep_wr_count", wr_n, 2);
    check("rep_wr_last_cycle", wr_cyc, 7);
    check("rep_done_count", done_n, 2);
    check("rep_done_first", done_first, 4);
    check("rep_done_second", done_last, 9);
    check("rep_final_addr", {23'd0, ram_addr}, 32'h066);
    check("rep_wdata", ram_wdata, 32'h1111_1111);

    // request arriving in DONE is dropped
    accept(1'b1, 1'b0, 32'h044, 32'h0, 32'h2468_1357);
    step(); step();
    start_read = 1'b1; addr_in = 32'h0EE;
    step();
    start_read = 1'b0;
    for (int c = 0; c < 5; c++) step();
    check("dn_rd_cycles", rd_n, 2);
    check("dn_done_count", done_n, 1);
    check("dn_busy_cycles", busy_n, 3);
    check("dn_addr", {23'd0, ram_addr}, 32'h044);
    check("dn_rdata", rdata_out, 32'h2468_1357);

    // reset during WR_PULSE
    accept(1'b0, 1'b1, 32'h033, 32'h7777_7777, 32'h0);
    step();
    clr = 1'b1;
    step();
    check("wclr_pulse_seen", wr_cyc, 2);
    @(negedge clk);
    check("wclr_strobes", {ram_read, ram_write, busy, done, addr_err}, 32'h0);
    check("wclr_addr", {23'd0, ram_addr}, 32'h0);
    check("wclr_wdata", ram_wdata, 32'h0);
    check("wclr_rdata", rdata_out, 32'h0);
    @(posedge clk); #1;
    clr = 1'b0;
    clear_obs();
    for (int c = 0; c < 5; c++) step();
    check("wclr_no_done", done_n, 0);
    check("wclr_no_write", wr_n, 0);

    // reset during RD
    accept(1'b1, 1'b0, 32'h0C3, 32'h0, 32'h1357_2468);
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int c = 0; c < 5; c++) step();
    check("rclr_rd_cycles", rd_n, 1);
    check("rclr_no_done", done_n, 0);
    check("rclr_rdata", rdata_out, 32'h0);
    check("rclr_busy", {31'd0, busy}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
